// File: rtl/stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_arbiter
// Purpose  : Two-requester stream arbiter with burst-limited alternation and
//            a single registered output stage (latency 1).
// Revision : 1.0
// ============================================================================
module stream_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_MAX  = 16,
    parameter string       OUT_ZERO   = "FALSE"
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_src,
    output logic [1:0]            grant
);

    localparam logic [1:0]  S_IDLE       = 2'd0;
    localparam logic [1:0]  S_GRANT0     = 2'd1;
    localparam logic [1:0]  S_GRANT1     = 2'd2;
    localparam logic [15:0] C_BURST_LAST = 16'(BURST_MAX - 1);
    localparam bit          C_OUT_ZERO   = (OUT_ZERO == "TRUE");

    logic [1:0]            state_q, state_d;
    logic                  last_q, last_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  settle_q, settle_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  src_q, src_d;

    logic                  w_load_ok;
    logic                  w_cur;
    logic                  w_cur_valid;
    logic                  w_oth_valid;
    logic                  w_acc;
    logic [1:0]            w_oth_state;
    logic [DATA_WIDTH-1:0] w_cur_data;

    assign w_load_ok   = ~valid_q | out_ready;
    assign w_cur       = (state_q == S_GRANT1);
    assign w_oth_state = w_cur ? S_GRANT0 : S_GRANT1;
    assign w_cur_valid = w_cur ? in1_valid : in0_valid;
    assign w_oth_valid = w_cur ? in0_valid : in1_valid;
    assign w_cur_data  = w_cur ? in1_data  : in0_data;

    // A fresh grant spends one settle cycle before it may accept a beat.
    assign in0_ready = (state_q == S_GRANT0) & w_load_ok & ~settle_q;
    assign in1_ready = (state_q == S_GRANT1) & w_load_ok & ~settle_q;
    assign w_acc     = (in0_valid & in0_ready) | (in1_valid & in1_ready);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        settle_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (in0_valid && in1_valid) begin
                    state_d  = last_q ? S_GRANT0 : S_GRANT1;
                    settle_d = 1'b1;
                end else if (in0_valid) begin
                    state_d  = S_GRANT0;
                    settle_d = 1'b1;
                end else if (in1_valid) begin
                    state_d  = S_GRANT1;
                    settle_d = 1'b1;
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (!w_cur_valid) begin
                    last_d = w_cur;
                    cnt_d  = '0;
                    if (w_oth_valid) begin
                        state_d  = w_oth_state;
                        settle_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (w_acc) begin
                    // Burst limit only hands over when the other side is waiting;
                    // otherwise the count saturates and the stream continues.
                    if (cnt_q == C_BURST_LAST) begin
                        if (w_oth_valid) begin
                            state_d  = w_oth_state;
                            last_d   = w_cur;
                            cnt_d    = '0;
                            settle_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        src_d   = src_q;
        if (w_acc) begin
            valid_d = 1'b1;
            data_d  = w_cur_data;
            src_d   = w_cur;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            if (C_OUT_ZERO) begin
                data_d = '0;
                src_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            settle_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            src_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            src_q    <= src_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_src   = src_q;
    assign grant     = {state_q == S_GRANT1, state_q == S_GRANT0};

endmodule
`default_nettype wire

// File: tb/tb_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_arbiter
// Purpose  : Self-checking bench for stream_arbiter (BURST_MAX=4, OUT_ZERO on).
// Revision : 1.0
// ============================================================================
module tb_stream_arbiter;

    localparam int DW = 16;
    localparam int BM = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in0_data, in1_data, out_data;
    logic          in0_valid, in0_ready, in1_valid, in1_ready;
    logic          out_valid, out_ready, out_src;
    logic [1:0]    grant;

    stream_arbiter #(
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM),
        .OUT_ZERO   ("TRUE")
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .grant     (grant)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          v0, v1, ordy;
        logic [1:0]    g;
        logic          r0, r1, ov, src;
        logic [DW-1:0] d;
    } vec_t;

    vec_t tbl [14];
    int   n_cmp = 0;
    int   n_err = 0;
    int   seq0, seq1;
    int   exp_seq [2];
    int   wait_cnt [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 25) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic [1:0] g, logic r0, logic r1, logic ov, logic src,
                                logic [DW-1:0] d);
        vec_t v;
        v.v0 = 1'b1; v.v1 = 1'b1; v.ordy = 1'b1;
        v.g = g; v.r0 = r0; v.r1 = r1; v.ov = ov; v.src = src; v.d = d;
        return v;
    endfunction

    // One clock of the reference model: inputs are set by the caller just after
    // a rising edge; handshakes are observed mid-cycle and the registered
    // output is predicted for the following cycle.
    task automatic tick();
        logic          hs0, hs1, ohs, pov, psrc, vn, hn;
        logic [DW-1:0] pdata, acc_data;
        int            s;
        in0_data = {1'b0, 15'(seq0)};
        in1_data = {1'b1, 15'(seq1)};
        @(negedge clock); #1;
        hs0   = in0_valid & in0_ready;
        hs1   = in1_valid & in1_ready;
        ohs   = out_valid & out_ready;
        pov   = out_valid;
        psrc  = out_src;
        pdata = out_data;
        chk("ready_exclusive", 32'(in0_ready & in1_ready), 32'd0);
        if (in0_ready) chk("ready0_grant", 32'(grant), 32'd1);
        if (in1_ready) chk("ready1_grant", 32'(grant), 32'd2);
        if (!out_valid) chk("zero_when_idle", 32'({out_src, out_data}), 32'd0);
        if (ohs) begin
            s = int'(out_src);
            chk("order", 32'(out_data), 32'({out_src, 15'(exp_seq[s])}));
            exp_seq[s]++;
        end
        for (int n = 0; n < 2; n++) begin
            vn = (n == 1) ? in1_valid : in0_valid;
            hn = (n == 1) ? hs1 : hs0;
            if (!vn || hn) begin
                wait_cnt[n] = 0;
            end else if (ohs && (int'(out_src) != n)) begin
                wait_cnt[n]++;
                chk("wait_bound", 32'(wait_cnt[n] <= BM + 2), 32'd1);
            end
        end
        acc_data = hs1 ? in1_data : in0_data;
        @(posedge clock); #1;
        if (hs0 || hs1) begin
            chk("lat1_valid", 32'(out_valid), 32'd1);
            chk("lat1_src", 32'(out_src), 32'(hs1));
            chk("lat1_data", 32'(out_data), 32'(acc_data));
        end else if (ohs) begin
            chk("drain_valid", 32'(out_valid), 32'd0);
        end else begin
            chk("hold", 32'({out_valid, out_src, out_data}), 32'({pov, psrc, pdata}));
        end
        if (hs0) seq0++;
        if (hs1) seq1++;
    endtask

    task automatic model_clear();
        seq0 = 0; seq1 = 0;
        exp_seq[0] = 0; exp_seq[1] = 0;
        wait_cnt[0] = 0; wait_cnt[1] = 0;
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: run still active, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, first, last, b;
        tbl[0]  = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tbl[1]  = mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tbl[2]  = mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tbl[3]  = mk(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111);
        tbl[4]  = mk(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111);
        tbl[5]  = mk(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111);
        tbl[6]  = mk(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1111);
        tbl[7]  = mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tbl[8]  = mk(2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 16'h2222);
        tbl[9]  = mk(2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 16'h2222);
        tbl[10] = mk(2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 16'h2222);
        tbl[11] = mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2222);
        tbl[12] = mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tbl[13] = mk(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111);

        reset_n   = 1'b0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        in0_data  = 16'h1111;
        in1_data  = 16'h2222;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_readies", 32'({in0_ready, in1_ready}), 32'd0);
        chk("reset_data_src", 32'({out_src, out_data}), 32'd0);
        reset_n = 1'b1;

        // Both requesters saturating, downstream always ready.
        for (int r = 0; r < 14; r++) begin
            in0_valid = tbl[r].v0;
            in1_valid = tbl[r].v1;
            out_ready = tbl[r].ordy;
            #1;
            chk($sformatf("row%0d_grant", r), 32'(grant), 32'(tbl[r].g));
            chk($sformatf("row%0d_ready", r), 32'({in0_ready, in1_ready}), 32'({tbl[r].r0, tbl[r].r1}));
            chk($sformatf("row%0d_valid", r), 32'(out_valid), 32'(tbl[r].ov));
            chk($sformatf("row%0d_src", r), 32'(out_src), 32'(tbl[r].src));
            chk($sformatf("row%0d_data", r), 32'(out_data), 32'(tbl[r].d));
            @(posedge clock); #1;
        end

        in0_valid = 1'b0;
        in1_valid = 1'b0;
        reset_n   = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        model_clear();

        // Downstream stall in the middle of an in0 stream.
        in0_valid = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_ready0", 32'(in0_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("release_accept", 32'(in0_valid & in0_ready), 32'd1);
            tick();
        end
        in0_valid = 1'b0;
        repeat (3) tick();

        // Lone in1 stream of 10 beats must not be cut by the burst limit.
        s = seq1; first = -1; last = -1;
        in1_valid = 1'b1;
        for (int i = 0; i < 40 && (seq1 - s) < 10; i++) begin
            b = seq1;
            tick();
            if (seq1 != b) begin
                if (first < 0) first = i;
                last = i;
            end
            if (first >= 0) chk("solo_grant", 32'(grant), 32'd2);
        end
        in1_valid = 1'b0;
        chk("solo_count", 32'(seq1 - s), 32'd10);
        chk("solo_no_bubble", 32'(last - first), 32'd9);
        repeat (3) tick();

        // Asynchronous reset in the middle of a burst.
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        repeat (7) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_readies", 32'({in0_ready, in1_ready}), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_seq[0] = seq0;
        exp_seq[1] = seq1;
        wait_cnt[0] = 0;
        wait_cnt[1] = 0;
        @(posedge clock); #1;
        chk("post_reset_tie", 32'(grant), 32'd1);
        repeat (6) tick();

        // Random traffic on every handshake.
        for (int i = 0; i < 10000; i++) begin
            int p;
            p = (i < 5000) ? 60 : 93;
            in0_valid = ($urandom_range(0, 99) < p);
            in1_valid = ($urandom_range(0, 99) < p);
            out_ready = ($urandom_range(0, 99) < 75);
            tick();
        end

        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("lossless0", 32'(exp_seq[0]), 32'(seq0));
        chk("lossless1", 32'(exp_seq[1]), 32'(seq1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of all data ports.
REQ-002 SHALL have parameter BURST_MAX, default 16, max beats per grant while the other input waits; legal range 1..65535.
REQ-003 SHALL have parameter OUT_ZERO, default "FALSE"; "TRUE" forces out_data=0 whenever out_valid=0.
REQ-004 SHALL have one clock and an asynchronous active-low reset, ports as the codebase names them: `clock`, `reset_n`.
REQ-005 clock  in  1  common clock for all I/O.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 in0_data  in  DATA_WIDTH  requester 0 data.
REQ-008 in0_valid  in  1  requester 0 data valid.
REQ-009 in0_ready  out  1  requester 0 beat accepted when high with in0_valid.
REQ-010 in1_data / in1_valid / in1_ready  in / in / out  DATA_WIDTH / 1 / 1  requester 1, same semantics.
REQ-011 out_data  out  DATA_WIDTH  registered output data.
REQ-012 out_valid  out  1  out_data valid.
REQ-013 out_ready  in  1  downstream accepts beat when high with out_valid.
REQ-014 out_src  out  1  requester index of the current out_data beat.
REQ-015 grant  out  2  one-hot current grant: 01=in0, 10=in1, 00=idle.

Function
REQ-016 A transfer SHALL occur on any port exactly when valid and ready are both high at a rising clock edge; no beat SHALL be lost or duplicated.
REQ-017 FSM states SHALL be IDLE, GRANT0, GRANT1.
REQ-018 Output stage SHALL be a single register; load_ok = ~out_valid | out_ready.
REQ-019 inN_ready SHALL be combinational: (state==GRANTn) & load_ok; the non-granted ready SHALL be 0.
REQ-020 An accepted input beat SHALL appear on out_data/out_valid/out_src one cycle later (latency 1).
REQ-021 With an input accept, out_valid SHALL become 1. Without one, an out_ready handshake SHALL set out_valid to 0. Otherwise out_valid SHALL hold.
REQ-022 IDLE: if exactly one inN_valid is high, the FSM SHALL go to GRANTn. If both are high, it SHALL go to the requester other than last_served. If neither, it SHALL stay IDLE.
REQ-023 IDLE SHALL accept no data; the first beat after a grant SHALL be accepted no earlier than the cycle after entering GRANTn.
REQ-024 beat_cnt SHALL count accepted beats in the current grant, 16 bits, reset to 0 on every grant change.
REQ-025 GRANTn with an accept, beat_cnt==BURST_MAX-1 and other valid high: the FSM SHALL switch to GRANTother, set last_served=n and clear beat_cnt.
REQ-026 GRANTn with an accept, beat_cnt==BURST_MAX-1 and other valid low: the FSM SHALL stay in GRANTn and beat_cnt SHALL saturate at BURST_MAX-1.
REQ-027 GRANTn with inN_valid=0: if the other valid is high, the FSM SHALL switch to GRANTother. Otherwise it SHALL go to IDLE. In both cases last_served=n.
REQ-028 A grant SHALL NOT change while out_valid=1 & out_ready=0 unless inN_valid=0; the stalled beat SHALL be held stable.
REQ-029 A requester dropping valid while its ready=0 SHALL NOT be treated as a transfer.
REQ-030 With OUT_ZERO="TRUE", out_data and out_src SHALL be 0 whenever out_valid=0; with "FALSE", they SHALL hold their last value.

Reset
REQ-031 reset_n=0 SHALL asynchronously force state=IDLE, last_served=1, beat_cnt=0, out_valid=0, out_data=0, out_src=0, grant=00. in0_ready and in1_ready SHALL then be 0.
REQ-032 Reset mid-transfer SHALL discard the output register contents. After release, the first grant SHALL follow REQ-022 with last_served=1, i.e. in0 wins a tie.
REQ-033 reset_n deassertion is synchronous to clock by the system; the block SHALL start arbitrating on the first edge after release.

Verification
REQ-034 After reset, in0 and in1 valid together, out_ready=1: grant=01 at cycle 1. out_valid=1 with out_src=0 at cycle 3.
REQ-035 BURST_MAX=4, both valid continuously, out_ready=1: out_src sequence 0,0,0,0,1,1,1,1,0,... with one bubble cycle per switch.
REQ-036 Only in1 streams 10 beats, BURST_MAX=4: the grant stays 10 and all 10 beats arrive in order with no bubbles.
REQ-037 out_ready=0 for 5 cycles mid-stream: out_data is stable, and in0_ready=0 during the stall. Exactly one beat is accepted per released cycle, with no loss.
REQ-038 reset_n pulsed low mid-burst: out_valid and grant go 0 immediately, without waiting for a clock edge; the next arbitration favours in0.
REQ-039 Random valid/ready on all ports, 10k cycles: the scoreboard sees per-requester in-order, lossless, duplicate-free delivery. No requester waits more than BURST_MAX+2 output beats while valid.
